// File: rtl/udp_128bit_recv.sv
// udp_128bit_recv: strips the 2-byte sign header from a UDP payload and
// packs the JPEG bytes MSB-first into 128-bit words for the DDR3 writer.
// Ports:
//   i_udp_clk50m, i_rst       : clock, async active-high reset
//   i_en                      : enables acceptance of a packet start
//   i_udp_rx_start/len/de/    : UDP RX byte stream with start pulse,
//   i_udp_rx_data/err           payload length and abort
//   o_ddr3_wrdata/wr_req,     : word, request held until one-cycle ack
//   i_ddr3_wr_ack
//   o_wr_128_rank             : 1-based index of the presented word
//   o_last_frame_flag,        : sign header fields
//   o_mjpeg_frame_rank
//   o_udp_jpeg_len            : payload length minus the header
//   o_udp_frame_down          : packet fully written (pulse)
//   o_frame_err               : packet dropped (pulse)
//   o_busy, o_state           : status
module udp_128bit_recv #(
  parameter int MAX_WORDS = 127
) (
  input  logic         i_udp_clk50m,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_udp_rx_start,
  input  logic [15:0]  i_udp_rx_len,
  input  logic         i_udp_rx_de,
  input  logic [7:0]   i_udp_rx_data,
  input  logic         i_udp_rx_err,
  output logic [127:0] o_ddr3_wrdata,
  output logic         o_ddr3_wr_req,
  input  logic         i_ddr3_wr_ack,
  output logic [6:0]   o_wr_128_rank,
  output logic         o_last_frame_flag,
  output logic [14:0]  o_mjpeg_frame_rank,
  output logic [15:0]  o_udp_jpeg_len,
  output logic         o_udp_frame_down,
  output logic         o_frame_err,
  output logic         o_busy,
  output logic [3:0]   o_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_SIGN1  = 4'd1,
    S_SIGN2  = 4'd2,
    S_RECV   = 4'd3,
    S_FLUSH  = 4'd4,
    S_FINISH = 4'd5,
    S_DROP   = 4'd6
  } state_t;

  // Largest legal UDP length: header plus MAX_WORDS full words.
  localparam int LEN_LIM = MAX_WORDS * 16 + 2;

  state_t         state_q, state_d;
  logic [15:0]    len_q, len_d;
  logic           flag_q, flag_d;
  logic [14:0]    frank_q, frank_d;
  logic [127:0]   asm_q, asm_d;
  logic [3:0]     bcnt_q, bcnt_d;
  logic [15:0]    dcnt_q, dcnt_d;
  logic [127:0]   wdat_q, wdat_d;
  logic           req_q, req_d;
  logic [6:0]     wrank_q, wrank_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           pend_q, pend_d;

  logic [127:0]   slot;
  logic [127:0]   word;
  logic           free;
  logic           last;
  logic           abort;
  logic           bad_len;

  // The byte lands in its slot; slot 0 starts a fresh, zeroed word,
  // so a partial word is already left-aligned with zero padding.
  assign slot  = {i_udp_rx_data, 120'd0} >> {bcnt_q, 3'b000};
  assign word  = ((bcnt_q == 4'd0) ? 128'd0 : asm_q) | slot;
  // The output slot can take a new word if empty or being acked now.
  assign free  = ~req_q | i_ddr3_wr_ack;
  assign last  = (dcnt_q + 16'd1) == len_q;
  assign abort = i_udp_rx_err | i_udp_rx_start;
  assign bad_len = (i_udp_rx_len < 16'd3) ||
                   ({1'b0, i_udp_rx_len} > 17'(LEN_LIM));

  always_ff @(posedge i_udp_clk50m or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      flag_q  <= 1'b0;
      frank_q <= '0;
      asm_q   <= '0;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
      wdat_q  <= '0;
      req_q   <= 1'b0;
      wrank_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      flag_q  <= flag_d;
      frank_q <= frank_d;
      asm_q   <= asm_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      wdat_q  <= wdat_d;
      req_q   <= req_d;
      wrank_q <= wrank_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    flag_d  = flag_q;
    frank_d = frank_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    wdat_d  = wdat_q;
    req_d   = req_q & ~i_ddr3_wr_ack;
    wrank_d = wrank_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    pend_d  = pend_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_udp_rx_start && i_en) begin
          len_d  = i_udp_rx_len - 16'd2;
          busy_d = 1'b1;
          if (bad_len) begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end else begin
            state_d = S_SIGN1;
          end
        end
      end
      S_SIGN1: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DROP;
        end else if (i_udp_rx_de) begin
          flag_d        = i_udp_rx_data[7];
          frank_d[14:8] = i_udp_rx_data[6:0];
          state_d       = S_SIGN2;
        end
      end
      S_SIGN2: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DROP;
        end else if (i_udp_rx_de) begin
          frank_d[7:0] = i_udp_rx_data;
          bcnt_d       = '0;
          dcnt_d       = '0;
          asm_d        = '0;
          wrank_d      = '0;
          state_d      = S_RECV;
        end
      end
      S_RECV: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DROP;
        end else if (i_udp_rx_de) begin
          asm_d  = word;
          bcnt_d = bcnt_q + 4'd1;
          dcnt_d = dcnt_q + 16'd1;
          if (bcnt_q == 4'd15) begin
            // Full word with the slot still occupied: overflow.
            if (!free) begin
              err_d   = 1'b1;
              state_d = S_DROP;
            end else begin
              wdat_d  = word;
              req_d   = 1'b1;
              wrank_d = wrank_q + 7'd1;
              if (last) state_d = S_FLUSH;
            end
          end else if (last) begin
            state_d = S_FLUSH;
            // A partial tail waits in FLUSH if the slot is busy.
            if (free) begin
              wdat_d  = word;
              req_d   = 1'b1;
              wrank_d = wrank_q + 7'd1;
            end else begin
              pend_d = 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        if (abort) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = S_DROP;
        end else if (pend_q) begin
          if (free) begin
            wdat_d  = asm_q;
            req_d   = 1'b1;
            wrank_d = wrank_q + 7'd1;
            pend_d  = 1'b0;
          end
        end else if (free) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_DROP: begin
        pend_d = 1'b0;
        if (free) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_ddr3_wrdata      = wdat_q;
  assign o_ddr3_wr_req      = req_q;
  assign o_wr_128_rank      = wrank_q;
  assign o_last_frame_flag  = flag_q;
  assign o_mjpeg_frame_rank = frank_q;
  assign o_udp_jpeg_len     = len_q;
  assign o_udp_frame_down   = (state_q == S_FINISH);
  assign o_frame_err        = err_q;
  assign o_busy             = busy_q;
  assign o_state            = state_q;

endmodule

// File: tb/tb_udp_128bit_recv.sv
// tb_udp_128bit_recv: directed packets with a write scoreboard
// checked by an independent monitor on the DDR3 handshake.
`timescale 1ns/1ps
module tb_udp_128bit_recv;

  logic         clk = 1'b0;
  logic         rst, en, start, de, rerr, ack;
  logic [15:0]  len;
  logic [7:0]   data;
  logic [127:0] wrdata;
  logic         req;
  logic [6:0]   wrank;
  logic         lflag;
  logic [14:0]  frank;
  logic [15:0]  jlen;
  logic         down, ferr, busy;
  logic [3:0]   st;

  always #10 clk = ~clk;

  udp_128bit_recv dut (
    .i_udp_clk50m       (clk),
    .i_rst              (rst),
    .i_en               (en),
    .i_udp_rx_start     (start),
    .i_udp_rx_len       (len),
    .i_udp_rx_de        (de),
    .i_udp_rx_data      (data),
    .i_udp_rx_err       (rerr),
    .o_ddr3_wrdata      (wrdata),
    .o_ddr3_wr_req      (req),
    .i_ddr3_wr_ack      (ack),
    .o_wr_128_rank      (wrank),
    .o_last_frame_flag  (lflag),
    .o_mjpeg_frame_rank (frank),
    .o_udp_jpeg_len     (jlen),
    .o_udp_frame_down   (down),
    .o_frame_err        (ferr),
    .o_busy             (busy),
    .o_state            (st)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [6:0]   r;
  } exp_t;

  exp_t q[$];
  int vecs = 0;
  int bad = 0;
  int ack_dly = 3;
  int down_seen = 0;
  int err_seen = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkword(input logic [7:0] base,
                                          input int w, input int n);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      if (w * 16 + j < n)
        r[127 - 8 * j -: 8] = base + 8'(w * 16 + j);
    return r;
  endfunction

  task automatic push_pkt(input logic [7:0] base, input int n);
    for (int w = 0; w < (n + 15) / 16; w++)
      q.push_back('{mkword(base, w, n), 7'(w + 1)});
  endtask

  // Ack generator: ack goes high ack_dly cycles after a word loads.
  initial begin : ackgen
    int cnt;
    cnt = 0;
    ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack) begin
        ack = 1'b0;
        cnt = req ? 1 : 0;
      end else if (req) begin
        if (cnt >= ack_dly) ack = 1'b1;
        else cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (req && ack) begin
        if (q.size() == 0) begin
          vecs++;
          bad++;
          $display("FAIL unexpected_write: got %0h rank %0d want none",
                   wrdata, wrank);
        end else begin
          e = q.pop_front();
          chk("wrdata", wrdata, e.d);
          chk("wr_rank", 128'(wrank), 128'(e.r));
        end
      end
      if (down) down_seen++;
      if (ferr) err_seen++;
    end
  end

  // ev: 0 none, 1 rx_err, 2 start while busy, 3 stop (caller resets)
  task automatic send_pkt(input logic [15:0] l, input logic [15:0] hdr,
                          input int n, input int ev_at, input int ev,
                          input logic [7:0] base);
    @(posedge clk); #1;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    de    = 1'b1;
    data  = hdr[15:8];
    @(posedge clk); #1;
    data  = hdr[7:0];
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == ev_at) begin
        de = 1'b0;
        if (ev == 3) return;
        if (ev == 1) rerr = 1'b1;
        if (ev == 2) begin
          start = 1'b1;
          len   = 16'd18;
        end
        @(posedge clk); #1;
        rerr  = 1'b0;
        start = 1'b0;
        return;
      end
      data = base + 8'(i);
    end
    @(posedge clk); #1;
    de = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k;
    k = 0;
    repeat (2) @(negedge clk);
    while ((busy || st != 4'd0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic end_chk(input string name, input int d0, input int e0,
                         input int xd, input int xe);
    chk({name, "_down"}, 128'(down_seen - d0), 128'(xd));
    chk({name, "_err"}, 128'(err_seen - e0), 128'(xe));
    chk({name, "_left"}, 128'(q.size()), 128'(0));
  endtask

  initial begin : main
    int d0, e0;
    rst = 1'b1; en = 1'b1; start = 1'b0; de = 1'b0;
    rerr = 1'b0; len = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wrdata", wrdata, 128'd0);
    chk("rst_ctl", 128'({req, down, ferr, busy, lflag, st}), 128'd0);
    chk("rst_fields", 128'({wrank, frank, jlen}), 128'd0);
    rst = 1'b0;

    // single word
    d0 = down_seen; e0 = err_seen; ack_dly = 3;
    q.push_back('{128'h000102030405060708090A0B0C0D0E0F, 7'd1});
    send_pkt(16'd18, 16'h8005, 16, -1, 0, 8'h00);
    wait_idle("single", 100);
    end_chk("single", d0, e0, 1, 0);
    chk("single_flag", 128'(lflag), 128'(1));
    chk("single_frank", 128'(frank), 128'(5));
    chk("single_jlen", 128'(jlen), 128'(16));

    // partial final word
    d0 = down_seen; e0 = err_seen;
    q.push_back('{128'h404142434445464748494A4B4C4D4E4F, 7'd1});
    q.push_back('{128'h50515253000000000000000000000000, 7'd2});
    send_pkt(16'd22, 16'h1234, 20, -1, 0, 8'h40);
    wait_idle("partial", 100);
    end_chk("partial", d0, e0, 1, 0);
    chk("partial_flag", 128'(lflag), 128'(0));
    chk("partial_frank", 128'(frank), 128'h1234);
    chk("partial_jlen", 128'(jlen), 128'(20));

    // ack held off 16 cycles: overflow, word 1 still written
    d0 = down_seen; e0 = err_seen; ack_dly = 16;
    q.push_back('{128'h000102030405060708090A0B0C0D0E0F, 7'd1});
    send_pkt(16'd42, 16'h0009, 40, -1, 0, 8'h00);
    wait_idle("ovf", 100);
    end_chk("ovf", d0, e0, 0, 1);

    // ack in the same cycle the next word completes
    d0 = down_seen; e0 = err_seen; ack_dly = 15;
    push_pkt(8'h80, 40);
    send_pkt(16'd42, 16'h000A, 40, -1, 0, 8'h80);
    wait_idle("same", 100);
    end_chk("same", d0, e0, 1, 0);

    // len = 2
    d0 = down_seen; e0 = err_seen; ack_dly = 3;
    send_pkt(16'd2, 16'h0001, 0, -1, 0, 8'h00);
    wait_idle("len2", 50);
    end_chk("len2", d0, e0, 0, 1);
    chk("len2_jlen", 128'(jlen), 128'(0));

    // maximum length: 127 words
    d0 = down_seen; e0 = err_seen;
    push_pkt(8'h00, 2032);
    send_pkt(16'd2034, 16'h0007, 2032, -1, 0, 8'h00);
    wait_idle("max", 500);
    end_chk("max", d0, e0, 1, 0);
    chk("max_rank", 128'(wrank), 128'(127));

    // one byte over the limit
    d0 = down_seen; e0 = err_seen;
    send_pkt(16'd2035, 16'h0002, 0, -1, 0, 8'h00);
    wait_idle("over", 50);
    end_chk("over", d0, e0, 0, 1);
    chk("over_jlen", 128'(jlen), 128'(2033));

    // rx error at data byte 7, then a good packet
    d0 = down_seen; e0 = err_seen;
    send_pkt(16'd34, 16'h0003, 32, 7, 1, 8'h00);
    wait_idle("rxerr", 50);
    end_chk("rxerr", d0, e0, 0, 1);
    d0 = down_seen; e0 = err_seen;
    push_pkt(8'h10, 16);
    send_pkt(16'd18, 16'h0004, 16, -1, 0, 8'h10);
    wait_idle("after", 100);
    end_chk("after", d0, e0, 1, 0);

    // start while busy
    d0 = down_seen; e0 = err_seen;
    send_pkt(16'd34, 16'h0005, 32, 10, 2, 8'h00);
    wait_idle("sbusy", 50);
    end_chk("sbusy", d0, e0, 0, 1);

    // reset mid-RECV with a word pending
    d0 = down_seen; e0 = err_seen; ack_dly = 100;
    send_pkt(16'd50, 16'h8006, 48, 20, 3, 8'h00);
    chk("pre_rst_req", 128'(req), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_wrdata", wrdata, 128'd0);
    chk("mrst_ctl", 128'({req, down, ferr, busy, lflag, st}), 128'd0);
    chk("mrst_fields", 128'({wrank, frank, jlen}), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ack_dly = 3;
    @(negedge clk);
    chk("mrst_state", 128'(st), 128'(0));
    push_pkt(8'h20, 16);
    send_pkt(16'd18, 16'h0001, 16, -1, 0, 8'h20);
    wait_idle("mrst", 100);
    end_chk("mrst", d0, e0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule

// File: doc/udp_128bit_recv.md
# udp_128bit_recv

Receive-side counterpart of the 128-bit UDP sender. Takes UDP payload bytes from the UDP RX core and strips the 2-byte sign header `{last_frame_flag, mjpeg_frame_rank[14:0]}`. Packs the following JPEG bytes MSB-first into 128-bit words and hands each word to the DDR3 write path with a req/ack handshake. Runs in the 50 MHz UDP clock domain, between the UDP RX core and the DDR3 frame-buffer writer.

## Interface
Parameters:
- `MAX_WORDS`, default 127: maximum 128-bit words per packet; JPEG byte limit is `MAX_WORDS*16` (2032).

Ports:
- `i_udp_clk50m` in 1: sole clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_en` in 1: a packet start is accepted only while high.
- `i_udp_rx_start` in 1: one-cycle pulse at payload start; `i_udp_rx_len` is valid in the same cycle.
- `i_udp_rx_len` in 16: UDP payload length in bytes, including the 2 sign bytes.
- `i_udp_rx_de` in 1: `i_udp_rx_data` valid this cycle; at most one byte per cycle.
- `i_udp_rx_data` in 8: payload byte.
- `i_udp_rx_err` in 1: RX core abort (CRC or truncation).
- `o_ddr3_wrdata` out 128: packed word; first received byte is at [127:120].
- `o_ddr3_wr_req` out 1: word valid; held until acknowledged.
- `i_ddr3_wr_ack` in 1: one-cycle acknowledge.
- `o_wr_128_rank` out 7: index of the word on `o_ddr3_wrdata`; the first word of a packet is 1.
- `o_last_frame_flag` out 1: header bit 15.
- `o_mjpeg_frame_rank` out 15: header bits 14:0.
- `o_udp_jpeg_len` out 16: `i_udp_rx_len - 2`.
- `o_udp_frame_down` out 1: one-cycle pulse when a packet is fully written.
- `o_frame_err` out 1: one-cycle pulse when a packet is dropped.
- `o_busy` out 1: high from an accepted start until the block returns to IDLE.
- `o_state` out 4: current state encoding.

## Operation
- States, encoded 0–6: IDLE, SIGN_BYTE_1, SIGN_BYTE_2, RECV, FLUSH, FINISH, DROP.
- **IDLE:** on `i_udp_rx_start & i_en`:
  - latch the length, set `o_busy`, compute `o_udp_jpeg_len = len - 2` (16-bit).
  - if `len < 3` or `len - 2 > MAX_WORDS*16`: go to DROP and pulse `o_frame_err`.
  - otherwise go to SIGN_BYTE_1.
- **SIGN_BYTE_1:** on `de`, byte → `{o_last_frame_flag, o_mjpeg_frame_rank[14:8]}`; go to SIGN_BYTE_2.
- **SIGN_BYTE_2:** on `de`, byte → `o_mjpeg_frame_rank[7:0]`; clear the byte counters; go to RECV.
- **RECV:** on `de`:
  - shift the byte into the assembly register from the MSB side; increment the 4-bit in-word count and the 16-bit data count.
  - when the 16th byte of a word arrives: copy the assembled word to `o_ddr3_wrdata`, raise `o_ddr3_wr_req`, increment `o_wr_128_rank`.
  - when the data count reaches `o_udp_jpeg_len`, go to FLUSH.
- **FLUSH:**
  - If the final word is partial, issue it with the unfilled low bytes zero, still left-aligned.
  - Wait until no request is pending, then go to FINISH.
- **FINISH:** pulse `o_udp_frame_down`, clear `o_busy`, go to IDLE.
- **DROP:**
  - Discard all bytes.
  - Any pending request is still completed; it is never retracted.
  - Once nothing is pending, clear `o_busy` and go to IDLE.
- **Output buffering:** single-entry. A word completes while `o_ddr3_wr_req` is still high without `i_ddr3_wr_ack` in the same cycle → overflow: pulse `o_frame_err`, go to DROP, keep the pending word.
- **Abort:** `i_udp_rx_err` in SIGN_BYTE_1, SIGN_BYTE_2, RECV or FLUSH → pulse `o_frame_err`, go to DROP.
- **Start while busy:** `i_udp_rx_start` in any state other than IDLE is treated as an abort (same as `i_udp_rx_err`).
- **Header/length holding:** `o_last_frame_flag`, `o_mjpeg_frame_rank` and `o_udp_jpeg_len` hold until the next accepted start.

## Timing
- **Reset:** every output is 0; state is IDLE; the assembly register and all counters are 0.
- **Word latency:** `o_ddr3_wr_req` rises in the cycle after the 16th data byte is sampled.
- **Request clearing:** `o_ddr3_wr_req` falls in the cycle after `i_ddr3_wr_ack`.
- **Ack and word completion in the same cycle:** the new word loads, `o_ddr3_wr_req` stays high, and this is not an error.
- **Partial word:** issued in the cycle after the last byte.
- **Completion:** `o_udp_frame_down` is asserted exactly one cycle, in the cycle after the ack of the final word is sampled (in FINISH).
- **Byte rate:** sustains one byte per cycle indefinitely provided each ack arrives within 16 cycles of its request.
- **Mid-packet reset:** all outputs return to 0 immediately; there is no `o_frame_err` pulse.
- **Back-to-back packets:** a start in the cycle FINISH returns to IDLE is ignored; the block is ready one cycle later.

## Test plan
- **Single-word packet:** `len = 18`, header `0x8005`, bytes `0x00..0x0F`, ack 3 cycles after req → one word `0x000102…0F`, rank 1, `o_last_frame_flag = 1`, rank field `5`, `o_udp_jpeg_len = 16`, one `o_udp_frame_down` pulse.
- **Partial final word:** `len = 22` (20 data bytes) → word 1 full; word 2 = bytes 16..19 in [127:96] with the rest zero; ranks 1 then 2.
- **Ack timing:** ack held off 16 cycles → overflow: `o_frame_err`, DROP, the pending word is still written, no `o_udp_frame_down`. Repeat with ack arriving in the same cycle the next word completes → no error.
- **Length limits:** `len = 2` → `o_frame_err` with no writes; `len = 2034` (2032 data bytes) → 127 words, last rank 127; `len = 2035` → dropped.
- **RX error:** `i_udp_rx_err` at data byte 7 → `o_frame_err`, no write issued, `o_busy` falls, the next packet is received correctly.
- **Start while busy and async reset:** `i_udp_rx_start` asserted mid-RECV → abort behaviour (`o_frame_err`, DROP). Reset asserted mid-RECV → all outputs 0 in the same cycle, IDLE after release.
